// File: rtl/alu_ctl_pkg.sv
// Shared constants and state encoding for the multicycle ALU controller.
package alu_ctl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_SRL   = 6'd2;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  localparam logic [5:0] HILO_OPEN = 6'b111111;
  localparam logic [5:0] CODE_NONE = 6'd0;

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  function automatic logic is_multicycle(input logic [5:0] funct);
    return (funct == FUNCT_DIVU) || (funct == FUNCT_MULTU);
  endfunction

endpackage

// File: rtl/alu_ctl_mc_if.sv
// Control bus between the EX stage and the multicycle ALU controller.
interface alu_ctl_mc_if;
  logic [1:0] ALUOp;
  logic [5:0] Funct;
  logic       op_valid;
  logic       flush;
  logic [5:0] SignaltoALU;
  logic [5:0] SignaltoSHT;
  logic [5:0] SignaltoDIV;
  logic [5:0] SignaltoMUX;
  logic       stall;
  logic       hilo_we;
  logic       illegal;
  logic [7:0] cnt;

  modport master (
    output ALUOp, Funct, op_valid, flush,
    input  SignaltoALU, SignaltoSHT, SignaltoDIV, SignaltoMUX,
    input  stall, hilo_we, illegal, cnt
  );

  modport slave (
    input  ALUOp, Funct, op_valid, flush,
    output SignaltoALU, SignaltoSHT, SignaltoDIV, SignaltoMUX,
    output stall, hilo_we, illegal, cnt
  );
endinterface

// File: rtl/alu_funct_dec.sv
// Combinational ALUOp/Funct decode to a unit operation code.
module alu_funct_dec
  import alu_ctl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [5:0] code,
  output logic       illegal
);

  always_comb begin
    code    = CODE_NONE;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = FUNCT_ADD;
      ALUOP_SUB: code = FUNCT_SUB;
      ALUOP_RTYPE: begin
        if (funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT,
                          FUNCT_SRL, FUNCT_MFHI, FUNCT_MFLO, FUNCT_MULTU, FUNCT_DIVU})
          code = funct;
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctl_mc.sv
// ALU control with a multicycle divu/multu sequencer that stalls the pipe
// and opens the HI/LO write for one cycle on completion.
module alu_ctl_mc
  import alu_ctl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = DATA_W + 1,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctl_mc_if.slave  bus
);

  if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div
    $fatal(1, "DIV_CYCLES must be within 1..255");
  end
  if (MUL_CYCLES < 1 || MUL_CYCLES > 255) begin : g_bad_mul
    $fatal(1, "MUL_CYCLES must be within 1..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);
  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt_r, cnt_nx;
  logic [5:0] code_r, code_nx;
  logic [5:0] dec_code;
  logic       dec_illegal;
  logic       issue;
  logic [5:0] out_code;
  logic       stall, hilo_we, illegal;

  alu_funct_dec u_dec (
    .alu_op  (bus.ALUOp),
    .funct   (bus.Funct),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign issue = bus.op_valid && !bus.flush && (bus.ALUOp == ALUOP_RTYPE)
                 && is_multicycle(bus.Funct);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_r;
    code_nx  = code_r;
    out_code = dec_code;
    stall    = 1'b0;
    hilo_we  = 1'b0;
    illegal  = 1'b0;
    case (state)
      IDLE: begin
        illegal = dec_illegal;
        if (issue) begin
          stall    = 1'b1;
          code_nx  = bus.Funct;
          cnt_nx   = 8'd0;
          state_nx = (bus.Funct == FUNCT_DIVU) ? DIV : MUL;
        end
      end
      DIV, MUL: begin
        // Live ALUOp/Funct/op_valid are ignored until the operation retires.
        out_code = code_r;
        stall    = 1'b1;
        if (bus.flush) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt_r + 8'd1;
          if (cnt_r == ((state == DIV) ? DIV_LAST : MUL_LAST))
            state_nx = DONE;
        end
      end
      DONE: begin
        out_code = HILO_OPEN;
        hilo_we  = 1'b1;
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt_r  <= 8'd0;
      code_r <= CODE_NONE;
    end else begin
      state  <= state_nx;
      cnt_r  <= cnt_nx;
      code_r <= code_nx;
    end
  end

  assign bus.SignaltoALU = out_code;
  assign bus.SignaltoSHT = out_code;
  assign bus.SignaltoDIV = out_code;
  assign bus.SignaltoMUX = out_code;
  assign bus.stall       = stall;
  assign bus.hilo_we     = hilo_we;
  assign bus.illegal     = illegal;
  assign bus.cnt         = cnt_r;

endmodule

// File: tb/tb_alu_ctl_mc.sv
// Directed bench for alu_ctl_mc: decode table plus multicycle/flush/reset sequences.
module tb_alu_ctl_mc;

  logic       clk;
  logic       rst_n;
  int         sel;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       op_valid;
  logic       flush;
  int         total;
  int         bad;

  alu_ctl_mc_if ifa ();
  alu_ctl_mc_if ifb ();
  alu_ctl_mc_if ifc ();

  alu_ctl_mc #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
  alu_ctl_mc #(.DATA_W(32), .MUL_CYCLES(4)) dut_m4 (.clk(clk), .rst_n(rst_n), .bus(ifb));
  alu_ctl_mc #(.DATA_W(32), .DIV_CYCLES(1), .MUL_CYCLES(1)) dut_n1 (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Only the selected instance sees the stimulus; the others sit idle.
  assign ifa.ALUOp    = (sel == 0) ? alu_op : 2'b00;
  assign ifa.Funct    = (sel == 0) ? funct : 6'd0;
  assign ifa.op_valid = (sel == 0) ? op_valid : 1'b0;
  assign ifa.flush    = (sel == 0) ? flush : 1'b0;
  assign ifb.ALUOp    = (sel == 1) ? alu_op : 2'b00;
  assign ifb.Funct    = (sel == 1) ? funct : 6'd0;
  assign ifb.op_valid = (sel == 1) ? op_valid : 1'b0;
  assign ifb.flush    = (sel == 1) ? flush : 1'b0;
  assign ifc.ALUOp    = (sel == 2) ? alu_op : 2'b00;
  assign ifc.Funct    = (sel == 2) ? funct : 6'd0;
  assign ifc.op_valid = (sel == 2) ? op_valid : 1'b0;
  assign ifc.flush    = (sel == 2) ? flush : 1'b0;

  logic [23:0] o_codes;
  logic        o_stall, o_hilo, o_ill;
  logic [7:0]  o_cnt;

  assign o_codes = (sel == 0) ? {ifa.SignaltoALU, ifa.SignaltoSHT, ifa.SignaltoDIV, ifa.SignaltoMUX} :
                   (sel == 1) ? {ifb.SignaltoALU, ifb.SignaltoSHT, ifb.SignaltoDIV, ifb.SignaltoMUX} :
                                {ifc.SignaltoALU, ifc.SignaltoSHT, ifc.SignaltoDIV, ifc.SignaltoMUX};
  assign o_stall = (sel == 0) ? ifa.stall   : (sel == 1) ? ifb.stall   : ifc.stall;
  assign o_hilo  = (sel == 0) ? ifa.hilo_we : (sel == 1) ? ifb.hilo_we : ifc.hilo_we;
  assign o_ill   = (sel == 0) ? ifa.illegal : (sel == 1) ? ifb.illegal : ifc.illegal;
  assign o_cnt   = (sel == 0) ? ifa.cnt     : (sel == 1) ? ifb.cnt     : ifc.cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       op_valid;
    logic       flush;
    logic [5:0] exp_code;
    logic       exp_ill;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input logic [5:0] code, input logic stall_e,
                           input logic hilo_e, input int cnt_e);
    chk({name, ".codes"}, {8'd0, o_codes}, {8'd0, {4{code}}});
    chk({name, ".stall"}, {31'd0, o_stall}, {31'd0, stall_e});
    chk({name, ".hilo_we"}, {31'd0, o_hilo}, {31'd0, hilo_e});
    if (cnt_e >= 0) chk({name, ".cnt"}, {24'd0, o_cnt}, 32'(cnt_e));
  endtask

  // kill_c: cycle at which flush (or reset when use_rst) is applied, -1 for none.
  task automatic run_op(input int s, input logic [5:0] f, input int n,
                        input int kill_c, input bit use_rst, input string name);
    int last;
    int stall_n;
    int hilo_n;
    stall_n = 0;
    hilo_n  = 0;
    sel     = s;
    last    = (kill_c < 0) ? n + 2 : (use_rst ? kill_c + 1 : n + 3);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      alu_op   = 2'b10;
      funct    = (c == 0) ? f : 6'd36;
      op_valid = (c == 0) || (kill_c < 0);
      flush    = !use_rst && (c == kill_c);
      rst_n    = !(use_rst && (c == kill_c));
      #1;
      if (c == 0)
        chk_state({name, ".issue"}, f, 1'b1, 1'b0, -1);
      else if (kill_c >= 0 && c > kill_c)
        chk_state({name, ".idle"}, 6'd36, 1'b0, 1'b0, 0);
      else if (c <= n)
        chk_state({name, ".busy"}, f, 1'b1, 1'b0, c - 1);
      else if (c == n + 1)
        chk_state({name, ".done"}, 6'd63, 1'b0, 1'b1, -1);
      else
        chk_state({name, ".after"}, 6'd36, 1'b0, 1'b0, 0);
      stall_n += int'(o_stall);
      hilo_n  += int'(o_hilo);
    end
    if (kill_c < 0) begin
      chk({name, ".stall_cycles"}, 32'(stall_n), 32'(n + 1));
      chk({name, ".hilo_cycles"}, 32'(hilo_n), 32'd1);
    end else begin
      chk({name, ".hilo_never"}, 32'(hilo_n), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; op_valid = 1'b0; alu_op = 2'b00;
  endtask

  initial begin
    total = 0; bad = 0;
    vecs[0]  = '{2'b00, 6'd0,  1'b1, 1'b0, 6'd32, 1'b0};
    vecs[1]  = '{2'b01, 6'd0,  1'b1, 1'b0, 6'd34, 1'b0};
    vecs[2]  = '{2'b10, 6'd32, 1'b1, 1'b0, 6'd32, 1'b0};
    vecs[3]  = '{2'b10, 6'd34, 1'b1, 1'b0, 6'd34, 1'b0};
    vecs[4]  = '{2'b10, 6'd36, 1'b1, 1'b0, 6'd36, 1'b0};
    vecs[5]  = '{2'b10, 6'd37, 1'b1, 1'b0, 6'd37, 1'b0};
    vecs[6]  = '{2'b10, 6'd42, 1'b1, 1'b0, 6'd42, 1'b0};
    vecs[7]  = '{2'b10, 6'd2,  1'b1, 1'b0, 6'd2,  1'b0};
    vecs[8]  = '{2'b10, 6'd16, 1'b1, 1'b0, 6'd16, 1'b0};
    vecs[9]  = '{2'b10, 6'd18, 1'b1, 1'b0, 6'd18, 1'b0};
    vecs[10] = '{2'b10, 6'd63, 1'b1, 1'b0, 6'd0,  1'b1};
    vecs[11] = '{2'b11, 6'd32, 1'b1, 1'b0, 6'd0,  1'b1};
    vecs[12] = '{2'b10, 6'd27, 1'b0, 1'b0, 6'd27, 1'b0};
    vecs[13] = '{2'b10, 6'd25, 1'b1, 1'b1, 6'd25, 1'b0};

    sel = 0; alu_op = 2'b00; funct = 6'd0; op_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_state("reset", 6'd32, 1'b0, 1'b0, 0);
    chk("reset.illegal", {31'd0, o_ill}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Each vector is held two cycles: the second proves no state change.
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        alu_op   = vecs[i].alu_op;
        funct    = vecs[i].funct;
        op_valid = vecs[i].op_valid;
        flush    = vecs[i].flush;
        #1;
        chk_state($sformatf("vec%0d_%0d", i, k), vecs[i].exp_code, 1'b0, 1'b0, 0);
        chk($sformatf("vec%0d_%0d.illegal", i, k), {31'd0, o_ill}, {31'd0, vecs[i].exp_ill});
      end
    end
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0; alu_op = 2'b00;

    run_op(0, 6'd27, 33, -1, 1'b0, "divu");
    run_op(1, 6'd25, 4,  -1, 1'b0, "multu4");
    run_op(0, 6'd27, 33, 11, 1'b0, "divu_flush");
    run_op(0, 6'd27, 33, 21, 1'b1, "divu_rst");
    run_op(0, 6'd27, 33, -1, 1'b0, "divu_post_rst");
    run_op(2, 6'd27, 1,  -1, 1'b0, "divu_n1");
    run_op(2, 6'd25, 1,  -1, 1'b0, "multu_n1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctl_mc.md
ALU_CTL_MC -- requirements
Module: alu_ctl_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width served by the controlled units.
REQ-002 SHALL have parameter DIV_CYCLES, default DATA_W+1: EX cycles a divu occupies, legal range 1..255.
REQ-003 SHALL have parameter MUL_CYCLES, default DATA_W: EX cycles a multu occupies, legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port ALUOp, input, 2 bits: main-control ALU operation class.
REQ-007 SHALL have port Funct, input, 6 bits: R-type function field.
REQ-008 SHALL have port op_valid, input, 1 bit: a valid instruction is present in EX this cycle.
REQ-009 SHALL have port flush, input, 1 bit: kill the in-flight multicycle operation.
REQ-010 SHALL have ports SignaltoALU, SignaltoSHT, SignaltoDIV and SignaltoMUX, each output, 6 bits: unit operation code.
REQ-011 SHALL have port stall, output, 1 bit: freeze IF/ID/EX.
REQ-012 SHALL have port hilo_we, output, 1 bit: HI/LO write strobe.
REQ-013 SHALL have port illegal, output, 1 bit: undecodable Funct with ALUOp=2'b10.
REQ-014 SHALL have port cnt, output, 8 bits: current multicycle count, for debug.

Function
REQ-015 SHALL decode while IDLE: ALUOp 00 -> 6'd32 (add); 01 -> 6'd34 (sub); 10 -> Funct passed through if Funct is in {32,34,36,37,42,2,16,18,25,27}; all other cases -> 6'd0 with illegal=1.
REQ-016 SHALL use one state machine with states IDLE, DIV, MUL and DONE.
REQ-017 SHALL, in IDLE with op_valid=1, ALUOp=10 and flush=0, go to DIV for Funct=27 (divu) or to MUL for Funct=25 (multu), latch the code and clear cnt.
REQ-018 SHALL, in DIV or MUL, increment cnt by 1 each cycle; at cnt == N-1 (N = DIV_CYCLES or MUL_CYCLES) go to DONE.
REQ-019 SHALL, in DONE, hold for one cycle with hilo_we=1 and all four Signalto* outputs = 6'b111111 (HILO_OPEN), then go to IDLE.
REQ-020 SHALL, in DIV and MUL, drive the Signalto* outputs from the latched code, ignoring live ALUOp and Funct.
REQ-021 SHALL drive stall combinationally: 1 in the IDLE issue cycle of REQ-017, 1 in DIV and MUL, 0 in DONE and otherwise.
REQ-022 SHALL give this timing for a divu issued at cycle 0: stall=1 in cycles 0..DIV_CYCLES, hilo_we=1 in cycle DIV_CYCLES+1.
REQ-023 SHALL ignore op_valid while not in IDLE.
REQ-024 SHALL, on flush=1 in DIV or MUL, go to IDLE next cycle with cnt=0 and never assert hilo_we.
REQ-025 SHALL ignore flush in DONE (the write completes).
REQ-026 SHALL, on flush=1 in IDLE, suppress the start.
REQ-027 SHALL, when N=1, spend exactly one cycle in DIV or MUL.
REQ-028 SHALL hold hilo_we=0 and illegal=0 in every state other than those stated above.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge, force state=IDLE, cnt=0, latched code=0, hilo_we=0 and stall=0; this takes priority over flush and op_valid, including mid-operation.
REQ-030 SHALL, in the cycle after reset deassertion, be in IDLE and accept an issue.

Structure
REQ-031 SHALL place the Funct and ALUOp constants, HILO_OPEN and the state encoding in shared package alu_ctl_pkg.
REQ-032 SHALL implement the decode of REQ-015 as combinational sub-module alu_funct_dec, instantiated once.
REQ-033 SHALL reject DIV_CYCLES or MUL_CYCLES outside 1..255 at elaboration.

Verification
REQ-034 SHALL cover: ALUOp=10, Funct=36, op_valid=1 -> all Signalto*=36, stall=0, illegal=0.
REQ-035 SHALL cover: divu issued with defaults -> stall=1 for 34 cycles, then hilo_we=1 and Signalto*=6'b111111 for exactly 1 cycle, then IDLE.
REQ-036 SHALL cover: multu with MUL_CYCLES=4 and Funct changed to 36 mid-operation -> Signalto* stay 25 for 4 cycles, hilo_we at cycle 5.
REQ-037 SHALL cover: divu with flush at cnt=10 -> IDLE next cycle, cnt=0, hilo_we never 1.
REQ-038 SHALL cover: rst_n=0 at cnt=20 of divu -> next cycle stall=0, cnt=0, hilo_we=0, and a new issue is accepted.
REQ-039 SHALL cover: ALUOp=10 with Funct=63 -> illegal=1, Signalto*=0, no state change.
